// File: rtl/dbus_peri_master_pkg.sv
// Shared data-bus definitions plus the constants and state type
// used by the peripheral-side data-bus master.
package dbus_peri_master_pkg;

  // Request fields driven from the bus master towards the peripherals.
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] w_data;
    logic [3:0]  sel_byte;
    logic        w_en;
    logic        req;
  } type_dbus2peri_s;

  // Response fields returned by the selected peripheral.
  typedef struct packed {
    logic [31:0] r_data;
    logic        ack;
  } type_peri2dbus_s;

  // Master sequencing: wait for a command, run the bus cycle, hand back the response.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } type_dbus_mst_state_e;

  // Default number of wait cycles without ack before an error response.
  localparam int DBUS_MST_TIMEOUT_DEF = 255;

  // Default LSB of the 4-bit peripheral select field inside the byte address.
  localparam int DBUS_MST_SEL_LSB = 8;

endpackage

// File: rtl/dbus_peri_master_peri_addr_decode.sv
// Combinational address decode: the 4-bit select field becomes a one-hot
// peripheral select, and indices with no peripheral behind them flag dec_err.
module peri_addr_decode
  import dbus_peri_master_pkg::*;
#(
  parameter int NUM_PERI = 5,
  parameter int SEL_LSB  = DBUS_MST_SEL_LSB
) (
  input  logic [SEL_LSB+3:SEL_LSB] sel_field,
  output logic [NUM_PERI-1:0]      sel,
  output logic                     dec_err
);

  localparam logic [4:0] NUM_PERI_W = 5'(NUM_PERI);

  // Turn the select index into a one-hot vector and flag out-of-range indices.
  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_PERI; i++) begin
      if (sel_field == 4'(i)) begin
        sel[i] = 1'b1;
      end else begin
        sel[i] = 1'b0;
      end
    end
    dec_err = ({1'b0, sel_field} >= NUM_PERI_W);
  end

endmodule

// File: rtl/dbus_peri_master.sv
// Single-outstanding data-bus initiator for the peripheral cluster.
// Accepts one command, decodes it to a peripheral select, holds the bus
// request until ack or timeout, then presents a valid/ready response.
// All outputs come straight from registers.
module dbus_peri_master
  import dbus_peri_master_pkg::*;
#(
  parameter int NUM_PERI = 5,
  parameter int SEL_LSB  = DBUS_MST_SEL_LSB,
  parameter int TIMEOUT  = DBUS_MST_TIMEOUT_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  input  logic [31:0]         cmd_addr_i,
  input  logic [31:0]         cmd_wdata_i,
  input  logic                cmd_we_i,
  input  logic [3:0]          cmd_be_i,
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic [31:0]         rsp_rdata_o,
  output logic                rsp_err_o,
  output logic [NUM_PERI-1:0] peri_sel_o,
  output type_dbus2peri_s     master2dbus_o,
  input  type_peri2dbus_s     dbus2master_i
);

  localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT);

  type_dbus_mst_state_e state;
  logic [15:0]          wait_cnt;
  logic [NUM_PERI-1:0]  dec_sel;
  logic                 dec_err;

  peri_addr_decode #(
    .NUM_PERI (NUM_PERI),
    .SEL_LSB  (SEL_LSB)
  ) u_decode (
    .sel_field (cmd_addr_i[SEL_LSB+3:SEL_LSB]),
    .sel       (dec_sel),
    .dec_err   (dec_err)
  );

  // Transaction sequencer; the bus register doubles as the captured command.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      cmd_ready_o   <= 1'b1;
      rsp_valid_o   <= 1'b0;
      rsp_rdata_o   <= 32'd0;
      rsp_err_o     <= 1'b0;
      peri_sel_o    <= '0;
      master2dbus_o <= '0;
      wait_cnt      <= 16'd0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid_i) begin
            cmd_ready_o <= 1'b0;
            if (dec_err) begin
              // Nothing behind this index: answer with an error, no bus cycle.
              state       <= RESP;
              rsp_valid_o <= 1'b1;
              rsp_err_o   <= 1'b1;
              rsp_rdata_o <= 32'd0;
            end else begin
              state                  <= BUSY;
              peri_sel_o             <= dec_sel;
              master2dbus_o.addr     <= cmd_addr_i;
              master2dbus_o.w_data   <= cmd_wdata_i;
              master2dbus_o.sel_byte <= cmd_be_i;
              master2dbus_o.w_en     <= cmd_we_i;
              master2dbus_o.req      <= 1'b1;
              wait_cnt               <= 16'd0;
            end
          end
        end
        BUSY: begin
          if (dbus2master_i.ack) begin
            // Ack takes priority over a timeout landing on the same cycle.
            state         <= RESP;
            rsp_valid_o   <= 1'b1;
            rsp_err_o     <= 1'b0;
            rsp_rdata_o   <= master2dbus_o.w_en ? 32'd0 : dbus2master_i.r_data;
            peri_sel_o    <= '0;
            master2dbus_o <= '0;
          end else if (wait_cnt == TIMEOUT_CNT) begin
            state         <= RESP;
            rsp_valid_o   <= 1'b1;
            rsp_err_o     <= 1'b1;
            rsp_rdata_o   <= 32'd0;
            peri_sel_o    <= '0;
            master2dbus_o <= '0;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        RESP: begin
          if (rsp_ready_i) begin
            state       <= IDLE;
            cmd_ready_o <= 1'b1;
            rsp_valid_o <= 1'b0;
            rsp_err_o   <= 1'b0;
            rsp_rdata_o <= 32'd0;
          end
        end
        default: begin
          state         <= IDLE;
          cmd_ready_o   <= 1'b1;
          rsp_valid_o   <= 1'b0;
          rsp_err_o     <= 1'b0;
          rsp_rdata_o   <= 32'd0;
          peri_sel_o    <= '0;
          master2dbus_o <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dbus_peri_master.sv
// Self-checking bench for dbus_peri_master: directed cases followed by
// randomized transactions, each predicted from cycle-count rules.
module tb_dbus_peri_master;
  import dbus_peri_master_pkg::*;

  localparam int NP  = 5;
  localparam int TMO = 4;

  logic            clk;
  logic            rst;
  logic            cmd_valid;
  logic            cmd_ready;
  logic [31:0]     cmd_addr;
  logic [31:0]     cmd_wdata;
  logic            cmd_we;
  logic [3:0]      cmd_be;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [31:0]     rsp_rdata;
  logic            rsp_err;
  logic [NP-1:0]   peri_sel;
  type_dbus2peri_s bus;
  type_peri2dbus_s peri;

  int tests;
  int fails;

  dbus_peri_master #(
    .NUM_PERI (NP),
    .SEL_LSB  (8),
    .TIMEOUT  (TMO)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .cmd_valid_i   (cmd_valid),
    .cmd_ready_o   (cmd_ready),
    .cmd_addr_i    (cmd_addr),
    .cmd_wdata_i   (cmd_wdata),
    .cmd_we_i      (cmd_we),
    .cmd_be_i      (cmd_be),
    .rsp_valid_o   (rsp_valid),
    .rsp_ready_i   (rsp_ready),
    .rsp_rdata_o   (rsp_rdata),
    .rsp_err_o     (rsp_err),
    .peri_sel_o    (peri_sel),
    .master2dbus_o (bus),
    .dbus2master_i (peri)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic junk_cmd();
    cmd_valid = 1'($urandom_range(0, 1));
    cmd_addr  = $urandom;
    cmd_wdata = $urandom;
    cmd_we    = 1'($urandom_range(0, 1));
    cmd_be    = 4'($urandom_range(0, 15));
  endtask

  // Called at a falling edge with the DUT idle. ack_cyc = 0 means never ack.
  task automatic run_txn(input logic [31:0] addr, input logic [31:0] wdata, input logic we,
                         input logic [3:0] be, input int ack_cyc, input logic [31:0] ack_data,
                         input int hold, input bit do_reset);
    int          idx;
    bit          derr;
    int          req_cyc;
    bit          exp_err;
    logic [31:0] exp_rdata;
    logic [NP-1:0] exp_sel;

    idx     = int'(addr[11:8]);
    derr    = (idx >= NP);
    exp_sel = '0;
    if (derr) begin
      req_cyc = 0; exp_err = 1'b1; exp_rdata = 32'd0;
    end else if (ack_cyc >= 1 && ack_cyc <= TMO + 1) begin
      req_cyc = ack_cyc; exp_err = 1'b0; exp_rdata = we ? 32'd0 : ack_data;
      exp_sel[idx] = 1'b1;
    end else begin
      req_cyc = TMO + 1; exp_err = 1'b1; exp_rdata = 32'd0;
      exp_sel[idx] = 1'b1;
    end

    chk("idle_ready", 64'(cmd_ready), 64'd1);
    chk("idle_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("idle_req", 64'(bus.req), 64'd0);
    chk("idle_sel", 64'(peri_sel), 64'd0);
    cmd_valid = 1'b1; cmd_addr = addr; cmd_wdata = wdata; cmd_we = we; cmd_be = be;
    @(negedge clk);

    for (int c = 1; c <= req_cyc; c++) begin
      chk("busy_req", 64'(bus.req), 64'd1);
      chk("busy_sel", 64'(peri_sel), 64'(exp_sel));
      chk("busy_addr", 64'(bus.addr), 64'(addr));
      chk("busy_wdata", 64'(bus.w_data), 64'(wdata));
      chk("busy_wen", 64'(bus.w_en), 64'(we));
      chk("busy_be", 64'(bus.sel_byte), 64'(be));
      chk("busy_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("busy_ready", 64'(cmd_ready), 64'd0);
      junk_cmd();
      peri.ack    = (c == ack_cyc);
      peri.r_data = (c == ack_cyc) ? ack_data : $urandom;
      @(negedge clk);
    end

    for (int d = 0; d <= hold; d++) begin
      chk("rsp_valid", 64'(rsp_valid), 64'd1);
      chk("rsp_rdata", 64'(rsp_rdata), 64'(exp_rdata));
      chk("rsp_err", 64'(rsp_err), 64'(exp_err));
      chk("rsp_req", 64'(bus.req), 64'd0);
      chk("rsp_sel", 64'(peri_sel), 64'd0);
      chk("rsp_ready_low", 64'(cmd_ready), 64'd0);
      junk_cmd();
      peri.ack    = 1'($urandom_range(0, 1));
      peri.r_data = $urandom;
      if (d == hold && do_reset) begin
        rst = 1'b1; cmd_valid = 1'b0; peri.ack = 1'b0;
        #1;
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("rst_rdata", 64'(rsp_rdata), 64'd0);
        chk("rst_err", 64'(rsp_err), 64'd0);
        chk("rst_bus_zero", 64'(bus == '0), 64'd1);
        chk("rst_sel", 64'(peri_sel), 64'd0);
        @(negedge clk);
        rst = 1'b0;
      end else if (d == hold) begin
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("post_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("post_ready", 64'(cmd_ready), 64'd1);
        chk("post_bus_zero", 64'(bus == '0), 64'd1);
      end else begin
        rsp_ready = 1'b0;
        @(negedge clk);
      end
    end
    cmd_valid = 1'b0;
    peri.ack  = 1'b0;
  endtask

  initial begin
    logic [31:0] a;
    tests = 0; fails = 0;
    rst = 1'b1; cmd_valid = 1'b0; cmd_addr = 32'd0; cmd_wdata = 32'd0;
    cmd_we = 1'b0; cmd_be = 4'd0; rsp_ready = 1'b0; peri = '0;
    repeat (2) @(negedge clk);
    chk("reset_ready", 64'(cmd_ready), 64'd1);
    chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset_rdata", 64'(rsp_rdata), 64'd0);
    chk("reset_err", 64'(rsp_err), 64'd0);
    chk("reset_bus", 64'(bus == '0), 64'd1);
    chk("reset_sel", 64'(peri_sel), 64'd0);
    rst = 1'b0;

    // Directed cases.
    run_txn(32'h0000_0100, 32'h1111_2222, 1'b0, 4'hF, 3, 32'hA5A5_0F0F, 0, 1'b0);
    run_txn(32'h0000_0000, 32'h0000_00FF, 1'b1, 4'b0001, 1, 32'h5555_AAAA, 0, 1'b0);
    run_txn(32'h0000_0700, 32'h0, 1'b0, 4'hF, 1, 32'h1234_0000, 0, 1'b0);
    run_txn(32'h0000_0200, 32'h0, 1'b0, 4'hF, 0, 32'h0, 0, 1'b0);
    run_txn(32'h0000_0300, 32'h0, 1'b0, 4'hF, TMO + 1, 32'h1234_5678, 0, 1'b0);
    run_txn(32'h0000_0400, 32'h0, 1'b0, 4'hF, 2, 32'hDEAD_BEEF, 10, 1'b1);
    run_txn(32'h0000_0100, 32'hCAFE_F00D, 1'b0, 4'h3, 2, 32'h0BAD_CAFE, 1, 1'b0);

    // Randomized transactions, including decode errors, timeouts and resets.
    for (int n = 0; n < 150; n++) begin
      a = $urandom;
      a[11:8] = 4'($urandom_range(0, 7));
      run_txn(a, $urandom, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
              int'($urandom_range(0, 7)), $urandom, int'($urandom_range(0, 3)),
              ($urandom_range(0, 19) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
